// File: rtl/tex_flash_sched.sv
// rtl/tex_flash_sched.sv - round-robin sharing of one SPI texture flash between two readers
// Each grant runs one mode-0 READ: command byte, ADDR_W address bits, DATA_W bits back on io1.
module tex_flash_sched #(
  parameter int         ADDR_W = 24,
  parameter int         DATA_W = 6,
  parameter logic [7:0] CMD    = 8'h03,
  parameter int         GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  output logic              o_req1_ready,
  output logic              o_rsp_valid,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_tex_csb,
  output logic              o_tex_sclk,
  output logic              o_tex_out0,
  output logic              o_tex_oeb0,
  input  logic              i_tex_in1
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_GAP} state_t;

  localparam int SW = 8 + ADDR_W;
  localparam int CW = $clog2(SW + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t            state;
  logic              phase;
  logic [CW-1:0]     bit_cnt;
  logic [SW-2:0]     shreg;
  logic [DATA_W-2:0] rx;
  logic              cur_id;
  logic              rr_ptr;
  logic [GW-1:0]     gap_cnt;
  logic              idle;

  assign idle         = (state == S_IDLE);
  assign o_req0_ready = idle & i_req0_valid & (~i_req1_valid | ~rr_ptr);
  assign o_req1_ready = idle & i_req1_valid & (~i_req0_valid |  rr_ptr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx          <= '0;
      cur_id      <= 1'b0;
      rr_ptr      <= 1'b0;
      gap_cnt     <= '0;
      o_tex_csb   <= 1'b1;
      o_tex_sclk  <= 1'b0;
      o_tex_out0  <= 1'b0;
      o_tex_oeb0  <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= 1'b0;
      o_rsp_data  <= '0;
    end else begin
      o_rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (o_req0_ready | o_req1_ready) begin
            state      <= S_CMD;
            cur_id     <= o_req1_ready;
            rr_ptr     <= o_req0_ready;
            // MSB of the command goes straight to the pin; the rest waits in shreg
            shreg      <= {CMD[6:0], (o_req1_ready ? i_req1_addr : i_req0_addr)};
            o_tex_out0 <= CMD[7];
            o_tex_oeb0 <= 1'b0;
            o_tex_csb  <= 1'b0;
            phase      <= 1'b0;
            bit_cnt    <= '0;
          end
        end
        S_CMD, S_ADDR: begin
          phase      <= ~phase;
          o_tex_sclk <= ~phase;
          if (phase) begin
            shreg      <= {shreg[SW-3:0], 1'b0};
            o_tex_out0 <= shreg[SW-2];
            bit_cnt    <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(7)) state <= S_ADDR;
            if (bit_cnt == CW'(SW - 1)) begin
              state      <= S_DATA;
              bit_cnt    <= '0;
              o_tex_out0 <= 1'b0;
              o_tex_oeb0 <= 1'b1;
            end
          end
        end
        S_DATA: begin
          phase      <= ~phase;
          o_tex_sclk <= ~phase;
          if (phase) begin
            rx      <= (DATA_W-1)'({rx, i_tex_in1});
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(DATA_W - 1)) begin
              state       <= S_GAP;
              gap_cnt     <= GW'(GAP - 1);
              o_tex_csb   <= 1'b1;
              o_rsp_valid <= 1'b1;
              o_rsp_id    <= cur_id;
              o_rsp_data  <= {rx, i_tex_in1};
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
